// File: rtl/sd_audio_dma.sv
// Ping-pong refill DMA for the sigma-delta audio sample buffer.
// Streams words from system RAM into the two buffer halves, owns the
// audio active bit and pads with silence once a non-looping stream ends.
module sd_audio_dma #(
  parameter int unsigned HALF_WORDS = 512,
  parameter logic [31:0] BUF_BASE   = 32'h0000_0000,
  parameter logic [31:0] SILENCE    = 32'h8080_8080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [3:0]  cfg_addr,
  input  logic [3:0]  cfg_wstrb,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [31:0] rd_addr,
  input  logic [31:0] rd_rdata,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_wdata,
  output logic [3:0]  wr_wstrb,
  input  logic        play_half,
  output logic        audio_active,
  output logic        irq_o
);

  localparam int unsigned BUF_WORDS = 2 * HALF_WORDS;
  localparam int unsigned IDX_W     = $clog2(BUF_WORDS);
  localparam int unsigned CNT_W     = IDX_W + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PRIME  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_FILL   = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic [31:0]      src_q, src_d;
  logic [23:0]      len_q, len_d;
  logic             busy_q, busy_d;
  logic             underrun_q, underrun_d;
  logic             done_q, done_d;
  logic [31:0]      cursor_q, cursor_d;
  logic [23:0]      remain_q, remain_d;
  logic [IDX_W-1:0] buf_idx_q, buf_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_half_q, last_half_d;
  logic             play_prev_q, play_prev_d;
  logic             sil_q, sil_d;
  logic             drain_q, drain_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic [31:0]      cfg_rdata_q, cfg_rdata_d;
  logic             rd_valid_q, rd_valid_d;
  logic [31:0]      rd_addr_q, rd_addr_d;
  logic             wr_valid_q, wr_valid_d;
  logic [31:0]      wr_addr_q, wr_addr_d;
  logic [31:0]      wr_wdata_q, wr_wdata_d;
  logic [3:0]       wr_wstrb_q, wr_wstrb_d;
  logic             active_q, active_d;
  logic             irq_q, irq_d;

  logic             cfg_acc_c;
  logic             start_c;
  logic             stop_c;
  logic             toggle_c;
  logic [CNT_W-1:0] tgt_c;
  logic             unused_ok_c;

  assign cfg_acc_c   = cfg_valid & ~cfg_ready_q;
  // Run 0->1 written while idle launches a stream.
  assign start_c     = (state_q == S_IDLE) & cfg_acc_c & (cfg_addr[3:2] == 2'd0)
                       & cfg_wstrb[0] & cfg_wdata[0] & ~ctrl_q[0];
  assign stop_c      = busy_q & ~ctrl_q[0];
  assign toggle_c    = play_half ^ play_prev_q;
  assign tgt_c       = (state_q == S_PRIME) ? CNT_W'(BUF_WORDS) : CNT_W'(HALF_WORDS);
  assign unused_ok_c = ^cfg_addr[1:0];

  // Register file access, sequencer and bus master next-state logic.
  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    src_d       = src_q;
    len_d       = len_q;
    busy_d      = busy_q;
    underrun_d  = underrun_q;
    done_d      = done_q;
    cursor_d    = cursor_q;
    remain_d    = remain_q;
    buf_idx_d   = buf_idx_q;
    cnt_d       = cnt_q;
    last_half_d = last_half_q;
    play_prev_d = play_half;
    sil_d       = sil_q;
    drain_d     = drain_q;
    cfg_ready_d = 1'b0;
    cfg_rdata_d = '0;
    rd_valid_d  = rd_valid_q;
    rd_addr_d   = rd_addr_q;
    wr_valid_d  = wr_valid_q;
    wr_addr_d   = wr_addr_q;
    wr_wdata_d  = wr_wdata_q;
    active_d    = active_q;

    if (cfg_acc_c) begin
      cfg_ready_d = 1'b1;
      if (cfg_wstrb == 4'h0) begin
        case (cfg_addr[3:2])
          2'd0:    cfg_rdata_d = {29'd0, ctrl_q};
          2'd1:    cfg_rdata_d = src_q;
          2'd2:    cfg_rdata_d = {8'd0, len_q};
          default: cfg_rdata_d = {29'd0, done_q, underrun_q, busy_q};
        endcase
      end else begin
        case (cfg_addr[3:2])
          2'd0: if (cfg_wstrb[0]) ctrl_d = cfg_wdata[2:0];
          2'd1: begin
            for (int b = 0; b < 4; b++)
              if (cfg_wstrb[b]) src_d[8*b +: 8] = cfg_wdata[8*b +: 8];
            src_d[1:0] = 2'b00;
          end
          2'd2: begin
            for (int b = 0; b < 3; b++)
              if (cfg_wstrb[b]) len_d[8*b +: 8] = cfg_wdata[8*b +: 8];
          end
          default: begin
            if (cfg_wstrb[0] && cfg_wdata[1]) underrun_d = 1'b0;
            if (cfg_wstrb[0] && cfg_wdata[2]) done_d     = 1'b0;
          end
        endcase
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start_c) begin
          cursor_d  = src_q;
          remain_d  = len_q;
          buf_idx_d = '0;
          cnt_d     = '0;
          sil_d     = 1'b0;
          done_d    = 1'b0;
          busy_d    = 1'b1;
          state_d   = (len_q == 24'd0) ? S_FINISH : S_PRIME;
        end
      end

      S_PRIME, S_FILL: begin
        if (state_q == S_FILL && toggle_c) underrun_d = 1'b1;
        if (rd_valid_q) begin
          if (rd_ready) begin
            rd_valid_d = 1'b0;
            // Looping streams reload on the last word so no gap appears.
            if (remain_q == 24'd1 && ctrl_q[1]) begin
              cursor_d = src_q;
              remain_d = len_q;
            end else begin
              cursor_d = cursor_q + 32'd4;
              remain_d = remain_q - 24'd1;
            end
            if (stop_c) begin
              state_d = S_FINISH;
            end else begin
              wr_valid_d = 1'b1;
              wr_wdata_d = rd_rdata;
              wr_addr_d  = BUF_BASE + 32'({buf_idx_q, 2'b00});
            end
          end
        end else if (wr_valid_q) begin
          if (wr_ready) begin
            wr_valid_d = 1'b0;
            buf_idx_d  = buf_idx_q + IDX_W'(1);
            cnt_d      = cnt_q + CNT_W'(1);
            if (stop_c) begin
              state_d = S_FINISH;
            end else if (cnt_d == tgt_c) begin
              cnt_d = '0;
              if (state_q == S_PRIME) begin
                active_d    = 1'b1;
                last_half_d = play_half;
              end
              if (sil_q) begin
                drain_d = 1'b0;
                state_d = S_DRAIN;
              end else begin
                state_d = S_WAIT;
              end
            end
          end
        end else if (stop_c) begin
          state_d = S_FINISH;
        end else if (remain_q != 24'd0) begin
          rd_valid_d = 1'b1;
          rd_addr_d  = cursor_q;
        end else begin
          wr_valid_d = 1'b1;
          wr_wdata_d = SILENCE;
          wr_addr_d  = BUF_BASE + 32'({buf_idx_q, 2'b00});
          sil_d      = 1'b1;
        end
      end

      S_WAIT: begin
        if (stop_c) begin
          state_d = S_FINISH;
        end else if (play_half != last_half_q) begin
          last_half_d = play_half;
          buf_idx_d   = {last_half_q, {(IDX_W-1){1'b0}}};
          cnt_d       = '0;
          state_d     = S_FILL;
        end
      end

      S_DRAIN: begin
        if (stop_c) begin
          state_d = S_FINISH;
        end else if (toggle_c) begin
          if (drain_q) state_d = S_FINISH;
          drain_d = 1'b1;
        end
      end

      S_FINISH: begin
        active_d   = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        rd_valid_d = 1'b0;
        wr_valid_d = 1'b0;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    wr_wstrb_d = {4{wr_valid_d}};
    irq_d      = ctrl_d[2] & (done_d | underrun_d);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ctrl_q      <= '0;
      src_q       <= '0;
      len_q       <= '0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
      done_q      <= 1'b0;
      cursor_q    <= '0;
      remain_q    <= '0;
      buf_idx_q   <= '0;
      cnt_q       <= '0;
      last_half_q <= 1'b0;
      play_prev_q <= 1'b0;
      sil_q       <= 1'b0;
      drain_q     <= 1'b0;
      cfg_ready_q <= 1'b0;
      cfg_rdata_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_addr_q   <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_wdata_q  <= '0;
      wr_wstrb_q  <= '0;
      active_q    <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      src_q       <= src_d;
      len_q       <= len_d;
      busy_q      <= busy_d;
      underrun_q  <= underrun_d;
      done_q      <= done_d;
      cursor_q    <= cursor_d;
      remain_q    <= remain_d;
      buf_idx_q   <= buf_idx_d;
      cnt_q       <= cnt_d;
      last_half_q <= last_half_d;
      play_prev_q <= play_prev_d;
      sil_q       <= sil_d;
      drain_q     <= drain_d;
      cfg_ready_q <= cfg_ready_d;
      cfg_rdata_q <= cfg_rdata_d;
      rd_valid_q  <= rd_valid_d;
      rd_addr_q   <= rd_addr_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_wdata_q  <= wr_wdata_d;
      wr_wstrb_q  <= wr_wstrb_d;
      active_q    <= active_d;
      irq_q       <= irq_d;
    end
  end

  assign cfg_ready    = cfg_ready_q;
  assign cfg_rdata    = cfg_rdata_q;
  assign rd_valid     = rd_valid_q;
  assign rd_addr      = rd_addr_q;
  assign wr_valid     = wr_valid_q;
  assign wr_addr      = wr_addr_q;
  assign wr_wdata     = wr_wdata_q;
  assign wr_wstrb     = wr_wstrb_q;
  assign audio_active = active_q;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_sd_audio_dma.sv
// Directed bench for sd_audio_dma with a reduced buffer (16-word halves).
module tb_sd_audio_dma;

  localparam int unsigned HW  = 16;
  localparam logic [31:0] SIL = 32'h8080_8080;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid, cfg_ready;
  logic [3:0]  cfg_addr, cfg_wstrb;
  logic [31:0] cfg_wdata, cfg_rdata;
  logic        rd_valid, rd_ready;
  logic [31:0] rd_addr, rd_rdata;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_addr, wr_wdata;
  logic [3:0]  wr_wstrb;
  logic        play_half, audio_active, irq_o;

  int checks = 0;
  int errors = 0;
  int stall = 0;
  int stab_err = 0;
  bit active_seen = 1'b0;
  logic [31:0] ra_q[$];
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [31:0] rdv;

  sd_audio_dma #(.HALF_WORDS(HW)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
    .cfg_wstrb(cfg_wstrb), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_rdata(rd_rdata),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_wdata(wr_wdata), .wr_wstrb(wr_wstrb),
    .play_half(play_half), .audio_active(audio_active), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  // Memory holds its own word index starting at 0x1000.
  assign rd_rdata = (rd_addr - 32'h0000_1000) >> 2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    check(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_addr = a; cfg_wdata = d; cfg_wstrb = s;
    n = 0;
    do begin @(negedge clk); n++; end while (!cfg_ready && n < 8);
    check1("cfg_wr_ack", cfg_ready, 1'b1);
    cfg_valid = 1'b0; cfg_wstrb = 4'h0;
  endtask

  task automatic cfg_read(input logic [3:0] a, output logic [31:0] d);
    int n;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_addr = a; cfg_wstrb = 4'h0;
    n = 0;
    do begin @(negedge clk); n++; end while (!cfg_ready && n < 8);
    check1("cfg_rd_ack", cfg_ready, 1'b1);
    d = cfg_rdata;
    cfg_valid = 1'b0;
  endtask

  task automatic clear_logs();
    ra_q.delete(); wa_q.delete(); wd_q.delete();
  endtask

  // Bus responders with programmable stall, plus handshake logging and stability monitoring.
  initial begin
    int rw, ww;
    logic rpend, wpend;
    logic [31:0] rpa, wpa, wpd;
    rw = 0; ww = 0; rpend = 1'b0; wpend = 1'b0;
    rpa = '0; wpa = '0; wpd = '0;
    rd_ready = 1'b0; wr_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_ready = 1'b0; wr_ready = 1'b0; rpend = 1'b0; wpend = 1'b0; rw = 0; ww = 0;
        continue;
      end
      if (rd_valid && wr_valid) stab_err++;
      if (rpend && (!rd_valid || rd_addr !== rpa)) stab_err++;
      if (wpend && (!wr_valid || wr_addr !== wpa || wr_wdata !== wpd || wr_wstrb !== 4'hf)) stab_err++;
      if (audio_active) active_seen = 1'b1;
      if (rd_valid) begin
        if (rw >= stall) begin rd_ready = 1'b1; rw = 0; end
        else begin rd_ready = 1'b0; rw++; end
      end else begin rd_ready = 1'b0; rw = 0; end
      if (wr_valid) begin
        if (ww >= stall) begin wr_ready = 1'b1; ww = 0; end
        else begin wr_ready = 1'b0; ww++; end
      end else begin wr_ready = 1'b0; ww = 0; end
      rpend = rd_valid && !rd_ready; rpa = rd_addr;
      wpend = wr_valid && !wr_ready; wpa = wr_addr; wpd = wr_wdata;
      if (rd_valid && rd_ready) ra_q.push_back(rd_addr);
      if (wr_valid && wr_ready) begin wa_q.push_back(wr_addr); wd_q.push_back(wr_wdata); end
    end
  end

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_addr = 4'h0; cfg_wstrb = 4'h0; cfg_wdata = '0;
    play_half = 1'b0;
    repeat (3) @(negedge clk);
    // Reset state.
    check("rst_ctl", {27'd0, cfg_ready, rd_valid, wr_valid, audio_active, irq_o}, 32'd0);
    check("rst_rdaddr", rd_addr, 32'd0);
    check("rst_wraddr", wr_addr, 32'd0);
    check("rst_wstrb", {28'd0, wr_wstrb}, 32'd0);
    rst = 1'b0;
    cfg_read(4'hC, rdv); check("rst_status", rdv, 32'd0);

    // 1: prime full buffer then refill half 0 on first toggle.
    cfg_write(4'h4, 32'h0000_1000, 4'hf);
    cfg_write(4'h8, 32'd64, 4'hf);
    cfg_write(4'h0, 32'h1, 4'hf);
    for (int n = 0; n < 2000 && !audio_active; n++) @(negedge clk);
    check1("t1_active", audio_active, 1'b1);
    check("t1_nrd", 32'(ra_q.size()), 32'd32);
    check("t1_nwr", 32'(wd_q.size()), 32'd32);
    check("t1_d0", wd_q[0], 32'd0);
    check("t1_d31", wd_q[31], 32'd31);
    check("t1_a31", wa_q[31], 32'h7C);
    cfg_read(4'hC, rdv); check("t1_busy", rdv, 32'h1);
    clear_logs();
    play_half = 1'b1;
    for (int n = 0; n < 500 && wd_q.size() < 16; n++) @(negedge clk);
    repeat (10) @(negedge clk);
    check("t1_fill_n", 32'(wd_q.size()), 32'd16);
    check("t1_fill_a0", wa_q[0], 32'h0);
    check("t1_fill_a15", wa_q[15], 32'h3C);
    check("t1_fill_d0", wd_q[0], 32'd32);
    check("t1_fill_d15", wd_q[15], 32'd47);
    check("t1_fill_ra0", ra_q[0], 32'h1080);
    cfg_write(4'h0, 32'h0, 4'hf);
    repeat (3) @(negedge clk);
    check1("t1_stop_act", audio_active, 1'b0);
    cfg_read(4'hC, rdv); check("t1_stop_st", rdv, 32'h4);

    // 2: short stream padded with silence, drained by two toggles, irq enabled.
    clear_logs();
    cfg_write(4'h8, 32'd20, 4'hf);
    cfg_write(4'h0, 32'h5, 4'hf);
    for (int n = 0; n < 2000 && !audio_active; n++) @(negedge clk);
    check1("t2_active", audio_active, 1'b1);
    check("t2_nrd", 32'(ra_q.size()), 32'd20);
    check("t2_nwr", 32'(wd_q.size()), 32'd32);
    check("t2_d19", wd_q[19], 32'd19);
    check("t2_d20", wd_q[20], SIL);
    check("t2_d31", wd_q[31], SIL);
    play_half = 1'b0;
    repeat (4) @(negedge clk);
    check1("t2_drain1", audio_active, 1'b1);
    play_half = 1'b1;
    repeat (4) @(negedge clk);
    check1("t2_drain2", audio_active, 1'b0);
    check1("t2_irq", irq_o, 1'b1);
    cfg_read(4'hC, rdv); check("t2_status", rdv, 32'h4);
    cfg_write(4'h0, 32'h0, 4'hf);
    check1("t2_irq_off", irq_o, 1'b0);

    // 3: looping three-word stream.
    clear_logs();
    cfg_write(4'h8, 32'd3, 4'hf);
    cfg_write(4'h0, 32'h3, 4'hf);
    for (int n = 0; n < 2000 && !audio_active; n++) @(negedge clk);
    check("t3_nwr", 32'(wd_q.size()), 32'd32);
    check("t3_d3", wd_q[3], 32'd0);
    check("t3_d5", wd_q[5], 32'd2);
    check("t3_d31", wd_q[31], 32'd1);
    check("t3_ra2", ra_q[2], 32'h1008);
    check("t3_ra3", ra_q[3], 32'h1000);
    cfg_write(4'h0, 32'h0, 4'hf);

    // 4: stalled fill with two toggles -> underrun, then W1C.
    clear_logs();
    cfg_write(4'h8, 32'd64, 4'hf);
    cfg_write(4'h0, 32'h1, 4'hf);
    for (int n = 0; n < 2000 && !audio_active; n++) @(negedge clk);
    check1("t4_active", audio_active, 1'b1);
    clear_logs();
    stall = 20;
    play_half = 1'b0;
    repeat (100) @(negedge clk);
    play_half = 1'b1;
    repeat (100) @(negedge clk);
    play_half = 1'b0;
    for (int n = 0; n < 3000 && wd_q.size() < 16; n++) @(negedge clk);
    check("t4_nwr", 32'(wd_q.size()), 32'd16);
    check("t4_a0", wa_q[0], 32'h40);
    check("t4_d0", wd_q[0], 32'd32);
    check("t4_stable", 32'(stab_err), 32'd0);
    cfg_read(4'hC, rdv); check("t4_underrun", rdv, 32'h3);
    cfg_write(4'hC, 32'h2, 4'h1);
    cfg_read(4'hC, rdv); check("t4_w1c", rdv, 32'h1);

    // 5: stop while a read is stalled.
    play_half = 1'b1;
    for (int n = 0; n < 100 && !rd_valid; n++) @(negedge clk);
    check1("t5_rdv", rd_valid, 1'b1);
    clear_logs();
    cfg_write(4'h0, 32'h0, 4'hf);
    for (int n = 0; n < 200 && audio_active; n++) @(negedge clk);
    repeat (2) @(negedge clk);
    check1("t5_act", audio_active, 1'b0);
    check("t5_nrd", 32'(ra_q.size()), 32'd1);
    check("t5_nwr", 32'(wd_q.size()), 32'd0);
    cfg_read(4'hC, rdv); check("t5_status", rdv, 32'h4);

    // 5b: async reset in the middle of a fill.
    stall = 2;
    cfg_write(4'h0, 32'h1, 4'hf);
    for (int n = 0; n < 2000 && !audio_active; n++) @(negedge clk);
    play_half = 1'b0;
    for (int n = 0; n < 200 && !wr_valid; n++) @(negedge clk);
    check1("t5_wrv", wr_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_ctl", {27'd0, cfg_ready, rd_valid, wr_valid, audio_active, irq_o}, 32'd0);
    check("t5_rst_wr", wr_addr | wr_wdata | {28'd0, wr_wstrb}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    stall = 0;
    cfg_read(4'h0, rdv); check("t5_rst_ctrl", rdv, 32'd0);

    // 6: register masking and zero-length start.
    cfg_write(4'h4, 32'h0000_1003, 4'hf);
    cfg_read(4'h4, rdv); check("t6_src_align", rdv, 32'h1000);
    cfg_write(4'h8, 32'hAABB_CCDD, 4'hf);
    cfg_read(4'h8, rdv); check("t6_len24", rdv, 32'h00BB_CCDD);
    cfg_write(4'h8, 32'hFFFF_FF11, 4'h1);
    cfg_read(4'h8, rdv); check("t6_len_strb", rdv, 32'h00BB_CC11);
    cfg_write(4'h8, 32'h0, 4'hf);
    clear_logs();
    active_seen = 1'b0;
    cfg_write(4'h0, 32'h1, 4'hf);
    cfg_read(4'hC, rdv); check("t6_done", rdv, 32'h4);
    repeat (5) @(negedge clk);
    check("t6_traffic", 32'(ra_q.size() + wd_q.size()), 32'd0);
    check1("t6_noactive", active_seen, 1'b0);
    check("final_stable", 32'(stab_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
